// File: rtl/lag_link_scheduler.sv
// Link-aggregation scheduler for one output port.
// Physical lanes (PLs) compete for NL aggregated links. Once a multi-flit
// packet starts on a link, that link stays with its owner until the tail
// flit is sent. Grants are combinational, so a flit moves in the same
// cycle it is offered. Each link keeps a credit count that tracks free
// slots in its downstream buffer.
module lag_link_scheduler #(
    parameter int NV      = 4,
    parameter int NL      = 2,
    parameter int buf_len = 4,
    localparam int LW = (NL > 1) ? $clog2(NL) : 1,
    localparam int VW = (NV > 1) ? $clog2(NV) : 1,
    localparam int CW = $clog2(buf_len + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NV-1:0]    req,
    input  logic [NV-1:0]    req_tail,
    input  logic [NL-1:0]    cntrl_in,
    output logic [NV-1:0]    grant,
    output logic [NV*LW-1:0] grant_link,
    output logic [NL-1:0]    link_valid,
    output logic [NL*VW-1:0] link_src,
    output logic [NL-1:0]    link_locked
);

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } link_state_t;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(buf_len);

    link_state_t   state_r  [NL];
    link_state_t   state_s  [NL];
    logic [VW-1:0] owner_r  [NL];
    logic [VW-1:0] owner_s  [NL];
    logic [CW-1:0] credit_r [NL];
    logic [CW-1:0] credit_s [NL];
    logic [VW-1:0] rr_ptr_r;
    logic [VW-1:0] rr_ptr_s;

    logic [NV-1:0]    owns_s;
    logic [NV-1:0]    cand_s;
    logic [NV-1:0]    grant_s;
    logic [NL-1:0]    elig_s;
    logic [NL-1:0]    taken_s;
    logic [NL-1:0]    link_valid_s;
    logic [NV*LW-1:0] grant_link_s;
    logic [NL*VW-1:0] link_src_s;
    logic             alloc_s;
    logic [VW-1:0]    last_alloc_s;

    // Serve link owners first, then match free links to unowned requesters round-robin.
    always_comb begin : p_sched
        int   idx;
        logic placed;
        idx          = 0;
        placed       = 1'b0;
        owns_s       = '0;
        grant_s      = '0;
        elig_s       = '0;
        taken_s      = '0;
        link_valid_s = '0;
        grant_link_s = '0;
        link_src_s   = '0;
        alloc_s      = 1'b0;
        last_alloc_s = '0;

        for (int j = 0; j < NL; j++) begin
            if (state_r[j] == ST_LOCKED) begin
                // A locked link is reserved for its owner, even when the owner stalls.
                owns_s[owner_r[j]] = 1'b1;
                if (req[owner_r[j]] && (credit_r[j] != {CW{1'b0}})) begin
                    grant_s[owner_r[j]]                      = 1'b1;
                    grant_link_s[int'(owner_r[j])*LW +: LW]  = LW'(j);
                    link_valid_s[j]                          = 1'b1;
                    link_src_s[j*VW +: VW]                   = owner_r[j];
                end else begin
                    link_valid_s[j] = 1'b0;
                end
            end else begin
                elig_s[j] = (credit_r[j] != {CW{1'b0}});
            end
        end

        cand_s = req & ~owns_s;

        for (int k = 0; k < NV; k++) begin
            idx    = (int'(rr_ptr_r) + k) % NV;
            placed = 1'b0;
            for (int j = 0; j < NL; j++) begin
                if (cand_s[idx] && !placed && elig_s[j] && !taken_s[j]) begin
                    placed                       = 1'b1;
                    taken_s[j]                   = 1'b1;
                    grant_s[idx]                 = 1'b1;
                    grant_link_s[idx*LW +: LW]   = LW'(j);
                    link_valid_s[j]              = 1'b1;
                    link_src_s[j*VW +: VW]       = VW'(idx);
                    alloc_s                      = 1'b1;
                    last_alloc_s                 = VW'(idx);
                end else begin
                    placed = placed;
                end
            end
        end
    end

    // Next link ownership, credit counts and round-robin pointer.
    always_comb begin : p_next
        logic [VW-1:0] src;
        logic          ret;
        src = '0;
        ret = 1'b0;
        for (int j = 0; j < NL; j++) begin
            state_s[j] = state_r[j];
            owner_s[j] = owner_r[j];
            src        = link_src_s[j*VW +: VW];
            if (link_valid_s[j]) begin
                case (state_r[j])
                    ST_FREE: begin
                        // A head that is not also a tail claims the link for its packet.
                        if (!req_tail[src]) begin
                            state_s[j] = ST_LOCKED;
                            owner_s[j] = src;
                        end else begin
                            state_s[j] = ST_FREE;
                        end
                    end
                    ST_LOCKED: state_s[j] = req_tail[src] ? ST_FREE : ST_LOCKED;
                    default:   state_s[j] = ST_FREE;
                endcase
            end else begin
                state_s[j] = state_r[j];
            end
            // A return while already full cannot be real and is dropped.
            ret         = cntrl_in[j] && (credit_r[j] != CREDIT_MAX);
            credit_s[j] = credit_r[j] - CW'(link_valid_s[j]) + CW'(ret);
        end
        rr_ptr_s = alloc_s ? VW'((int'(last_alloc_s) + 1) % NV) : rr_ptr_r;
    end

    // State registers; reset abandons every lock and refills all credits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NL; j++) begin
                state_r[j]  <= ST_FREE;
                owner_r[j]  <= '0;
                credit_r[j] <= CREDIT_MAX;
            end
            rr_ptr_r <= '0;
        end else begin
            for (int j = 0; j < NL; j++) begin
                state_r[j]  <= state_s[j];
                owner_r[j]  <= owner_s[j];
                credit_r[j] <= credit_s[j];
            end
            rr_ptr_r <= rr_ptr_s;
        end
    end

    // Outputs are forced quiet while reset is asserted, whatever req says.
    always_comb begin : p_out
        grant       = rst_n ? grant_s      : '0;
        grant_link  = rst_n ? grant_link_s : '0;
        link_valid  = rst_n ? link_valid_s : '0;
        link_src    = rst_n ? link_src_s   : '0;
        link_locked = '0;
        for (int j = 0; j < NL; j++) begin
            link_locked[j] = rst_n && (state_r[j] == ST_LOCKED);
        end
    end

    for (genvar j = 0; j < NL; j++) begin : g_credit_chk
        a_credit_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(cntrl_in[j] && (credit_r[j] == CREDIT_MAX)));
    end

endmodule

// File: tb/tb_lag_link_scheduler.sv
// Scoreboard bench for lag_link_scheduler (NV=4, NL=2, buf_len=4).
// A queue/array reference model predicts each cycle's outputs; a separate
// monitor pops predictions and compares them to what the DUT presents.
module tb_lag_link_scheduler;

    localparam int NV  = 4;
    localparam int NL  = 2;
    localparam int BUF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic [3:0] req_tail = 4'h0;
    logic [1:0] cntrl_in = 2'b00;
    logic [3:0] grant;
    logic [3:0] grant_link;
    logic [1:0] link_valid;
    logic [3:0] link_src;
    logic [1:0] link_locked;

    lag_link_scheduler #(.NV(NV), .NL(NL), .buf_len(BUF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_tail   (req_tail),
        .cntrl_in   (cntrl_in),
        .grant      (grant),
        .grant_link (grant_link),
        .link_valid (link_valid),
        .link_src   (link_src),
        .link_locked(link_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] gl;
        logic [1:0] lv;
        logic [3:0] ls;
        logic [1:0] lk;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   popped = 0;

    int   m_credit[NL];
    bit   m_locked[NL];
    int   m_owner[NL];
    int   m_rr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int j = 0; j < NL; j++) begin
            m_credit[j] = BUF;
            m_locked[j] = 1'b0;
            m_owner[j]  = 0;
        end
        m_rr = 0;
    endfunction

    // Reference: owners keep their links, then rotate over unowned requesters.
    task automatic model_step(input logic [3:0] r, input logic [3:0] t, input logic [1:0] c,
                              output exp_t e);
        bit owned[NV];
        int cands[$];
        int links[$];
        int src[NL];
        bit lv[NL];
        int last;
        bit alloc;
        int i;
        int l;
        e.g = 4'h0; e.gl = 4'h0; e.lv = 2'b00; e.ls = 4'h0;
        e.lk = {m_locked[1], m_locked[0]};
        last = 0; alloc = 1'b0;
        for (int k = 0; k < NV; k++) owned[k] = 1'b0;
        for (int j = 0; j < NL; j++) begin
            src[j] = 0; lv[j] = 1'b0;
            if (m_locked[j]) begin
                owned[m_owner[j]] = 1'b1;
                if (r[m_owner[j]] && m_credit[j] > 0) begin
                    lv[j] = 1'b1; src[j] = m_owner[j];
                end
            end
        end
        for (int k = 0; k < NV; k++) begin
            i = (m_rr + k) % NV;
            if (r[i] && !owned[i]) cands.push_back(i);
        end
        for (int j = 0; j < NL; j++)
            if (!m_locked[j] && m_credit[j] > 0) links.push_back(j);
        while (cands.size() > 0 && links.size() > 0) begin
            i = cands.pop_front();
            l = links.pop_front();
            lv[l] = 1'b1; src[l] = i; last = i; alloc = 1'b1;
        end
        for (int j = 0; j < NL; j++) begin
            if (lv[j]) begin
                e.g[src[j]]      = 1'b1;
                e.gl[src[j]]     = (j == 1);
                e.lv[j]          = 1'b1;
                e.ls[j*2 +: 2]   = 2'(src[j]);
                if (m_locked[j]) begin
                    if (t[src[j]]) m_locked[j] = 1'b0;
                end else if (!t[src[j]]) begin
                    m_locked[j] = 1'b1;
                    m_owner[j]  = src[j];
                end
            end
            m_credit[j] = m_credit[j] - (lv[j] ? 1 : 0) + ((c[j] && m_credit[j] < BUF) ? 1 : 0);
        end
        if (alloc) m_rr = (last + 1) % NV;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic [3:0] r, input logic [3:0] t, input logic [1:0] c);
        exp_t e;
        req = r; req_tail = t; cntrl_in = c;
        model_step(r, t, c, e);
        sb_q.push_back(e);
        pushed++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'h0; req_tail = 4'h0; cntrl_in = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares what the DUT presents against the oldest prediction.
    initial begin : monitor
        exp_t e;
        logic [3:0] glm;
        logic [3:0] lsm;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                popped++;
                glm = grant_link & grant;
                lsm = link_src & {{2{link_valid[1]}}, {2{link_valid[0]}}};
                chk("grant", 32'(grant), 32'(e.g));
                chk("grant_link", 32'(glm), 32'(e.gl));
                chk("link_valid", 32'(link_valid), 32'(e.lv));
                chk("link_src", 32'(lsm), 32'(e.ls));
                chk("link_locked", 32'(link_locked), 32'(e.lk));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0] r;
        logic [3:0] t;
        logic [1:0] c;
        model_reset();
        rst_n = 1'b0; req = 4'hF;
        @(posedge clk);
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_link_valid", 32'(link_valid), 32'd0);
        chk("reset_link_locked", 32'(link_locked), 32'd0);
        req = 4'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Dual allocation from a fresh start.
        step(4'b1111, 4'b0000, 2'b00);
        chk("dual_locked", 32'(link_locked), 32'd3);

        // Credit exhaustion and a single credit return.
        do_reset();
        for (int n = 0; n < 5; n++) step(4'b0001, 4'b0000, 2'b00);
        step(4'b0001, 4'b0000, 2'b01);
        step(4'b0001, 4'b0000, 2'b00);
        step(4'b0001, 4'b0000, 2'b00);

        // Tail release, link0 goes to PL2 in round-robin order.
        do_reset();
        step(4'b1111, 4'b0000, 2'b00);
        step(4'b1111, 4'b0001, 2'b00);
        chk("release_locked", 32'(link_locked), 32'd2);
        step(4'b1110, 4'b0000, 2'b00);

        // Single-flit packet leaves link0 free.
        do_reset();
        step(4'b1000, 4'b1000, 2'b00);
        chk("single_flit_free", 32'(link_locked), 32'd0);
        step(4'b0000, 4'b0000, 2'b00);

        // Simultaneous use and return at credit 1.
        do_reset();
        step(4'b1111, 4'b0000, 2'b00);
        step(4'b0010, 4'b0000, 2'b00);
        step(4'b0010, 4'b0000, 2'b00);
        step(4'b0010, 4'b0000, 2'b10);
        step(4'b0010, 4'b0000, 2'b00);
        step(4'b0010, 4'b0000, 2'b00);

        // Asynchronous reset mid-packet.
        do_reset();
        step(4'b1111, 4'b0000, 2'b00);
        step(4'b1111, 4'b0000, 2'b00);
        req = 4'hF;
        rst_n = 1'b0;
        #1;
        chk("midreset_grant", 32'(grant), 32'd0);
        chk("midreset_link_valid", 32'(link_valid), 32'd0);
        chk("midreset_link_locked", 32'(link_locked), 32'd0);
        req = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 5; n++) step(4'b0011, 4'b0000, 2'b00);

        // Randomized traffic with credit returns only where the model has room.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = 4'($urandom_range(0, 15));
            t = 4'($urandom) & 4'($urandom);
            c = 2'b00;
            for (int j = 0; j < NL; j++)
                if (m_credit[j] < BUF && $urandom_range(0, 2) == 0) c[j] = 1'b1;
            step(r, t, c);
            if (n == 750) do_reset();
        end

        req = 4'h0; req_tail = 4'h0; cntrl_in = 2'b00;
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("pop_count", 32'(popped), 32'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
